mat_stream_loader: RTL

//   Upstream feeder for the matrix multiplier. Accepts one float element per

---
 rtl/mat_stream_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/mat_stream_loader.sv
// Stream-to-matrix loader: packs row-major float beats into a flat operand bus
// and hands the completed matrix to the multiplier over valid/ready.
module mat_stream_loader #(
  parameter int FLOAT_WIDTH = 32,
  parameter int ROWS        = 32,
  parameter int COLS        = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [FLOAT_WIDTH-1:0]              in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [ROWS*COLS*FLOAT_WIDTH-1:0]    mat_out,
  output logic                                mat_valid,
  input  logic                                mat_ready,
  output logic [$clog2(ROWS*COLS+1)-1:0]      fill_count,
  output logic                                err_frame
);

  localparam int TOTAL = ROWS * COLS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW   = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {FILL, FULL} state_t;

  state_t         state, state_nxt;
  logic [RW-1:0]  row;
  logic [CLW-1:0] col;
  logic           beat;
  logic           at_end;
  logic           frame_ok;

  // Handshake depends only on state, so there is no in_valid/mat_ready -> in_ready path.
  assign in_ready  = (state == FILL);
  assign mat_valid = (state == FULL);
  assign beat      = in_valid && in_ready;
  assign at_end    = (fill_count == CW'(TOTAL - 1));
  assign frame_ok  = at_end && in_last;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next state: a well-framed final beat fills; the consumer's ready drains.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (beat && frame_ok) state_nxt = FULL;
      FULL: if (mat_ready)        state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Write position and framing check; any frame end (good or bad) rewinds to element 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      fill_count <= '0;
      err_frame  <= 1'b0;
    end else begin
      err_frame <= 1'b0;
      if (beat) begin
        if (at_end || in_last) begin
          row        <= '0;
          col        <= '0;
          fill_count <= '0;
          err_frame  <= !frame_ok;
        end else begin
          fill_count <= fill_count + CW'(1);
          if (col == CLW'(COLS - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CLW'(1);
          end
        end
      end
    end
  end

  // One register slot per element; written only when a beat lands on its (row,col).
  for (genvar e = 0; e < TOTAL; e++) begin : g_elem
    logic wr;
    assign wr = beat && (row == RW'(e / COLS)) && (col == CLW'(e % COLS));

    // Element storage; stale contents survive an aborted frame.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  mat_out[e*FLOAT_WIDTH +: FLOAT_WIDTH] <= '0;
      else if (wr) mat_out[e*FLOAT_WIDTH +: FLOAT_WIDTH] <= in_data;
    end
  end

endmodule
